// File: rtl/local_mem_arb_pkg.sv
// Local-memory bank types shared with the bank model, plus arbiter-private
// state, tag and depth definitions.
package local_mem_cfg_pkg;
  localparam int LOCAL_MEM_ADDR_W    = 32;
  localparam int LOCAL_MEM_DATA_W    = 64;
  localparam int LOCAL_MEM_BURST_W   = 7;

  typedef logic [LOCAL_MEM_ADDR_W-1:0]   t_local_mem_addr;
  typedef logic [LOCAL_MEM_DATA_W-1:0]   t_local_mem_data;
  typedef logic [LOCAL_MEM_DATA_W/8-1:0] t_local_mem_byte_mask;
  typedef logic [LOCAL_MEM_BURST_W-1:0]  t_local_mem_burst_cnt;
endpackage

package local_mem_arb_pkg;
  import local_mem_cfg_pkg::*;

  localparam int DEFAULT_TAG_DEPTH = 16;

  typedef enum logic {
    ARB_IDLE     = 1'b0,
    ARB_WR_BURST = 1'b1
  } t_arb_state;

  typedef struct packed {
    logic                 id;
    t_local_mem_burst_cnt beats;
  } t_arb_tag;

  // A zero burst length moves exactly one beat on the bank.
  function automatic t_local_mem_burst_cnt eff_beats(input t_local_mem_burst_cnt bc);
    return (bc == '0) ? t_local_mem_burst_cnt'(1) : bc;
  endfunction
endpackage

// File: rtl/local_mem_arb_tag_fifo.sv
// Synchronous FIFO of outstanding read tags (owner id + beat count) with
// full/empty flags; pointers carry one wrap bit.
module local_mem_arb_tag_fifo
  import local_mem_arb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_TAG_DEPTH
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  t_arb_tag push_tag,
  input  logic     pop,
  output t_arb_tag head_tag,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);

  t_arb_tag         mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_tag;
  end

  assign head_tag = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/local_mem_arb.sv
// Two-requester arbiter onto one local-memory bank: zero-latency command mux,
// write-burst grant lock, in-order read response routing via a tag FIFO.
// Define LOCAL_MEM_ARB_RR_EN for round-robin arbitration (default: m0 wins).
module local_mem_arb
  import local_mem_cfg_pkg::*;
  import local_mem_arb_pkg::*;
#(
  parameter int TAG_DEPTH = DEFAULT_TAG_DEPTH
) (
  input  logic                 clk,
  input  logic                 SoftReset,

  input  t_local_mem_addr      m0_address,
  input  logic                 m0_read,
  input  logic                 m0_write,
  input  t_local_mem_data      m0_writedata,
  input  t_local_mem_byte_mask m0_byteenable,
  input  t_local_mem_burst_cnt m0_burstcount,
  output logic                 m0_waitrequest,
  output t_local_mem_data      m0_readdata,
  output logic                 m0_readdatavalid,

  input  t_local_mem_addr      m1_address,
  input  logic                 m1_read,
  input  logic                 m1_write,
  input  t_local_mem_data      m1_writedata,
  input  t_local_mem_byte_mask m1_byteenable,
  input  t_local_mem_burst_cnt m1_burstcount,
  output logic                 m1_waitrequest,
  output t_local_mem_data      m1_readdata,
  output logic                 m1_readdatavalid,

  output t_local_mem_addr      avs_address,
  output logic                 avs_read,
  output logic                 avs_write,
  output t_local_mem_data      avs_writedata,
  output t_local_mem_byte_mask avs_byteenable,
  output t_local_mem_burst_cnt avs_burstcount,
  input  logic                 avs_waitrequest,
  input  t_local_mem_data      avs_readdata,
  input  logic                 avs_readdatavalid,

  output logic                 rsp_error
);
  t_arb_state           state, state_nxt;
  logic                 lock_id, lock_id_nxt;
  t_local_mem_burst_cnt beats_left, beats_left_nxt;
  t_local_mem_burst_cnt head_cnt;

  logic     fifo_full, fifo_empty, fifo_push, fifo_pop;
  t_arb_tag head_tag, push_tag;

  logic gnt_vld, gnt_id;
  logic elig0, elig1;
  logic sel_read, sel_write;
  logic accept;
  logic rdv_hit, head_last;

`ifdef LOCAL_MEM_ARB_RR_EN
  logic last_acc_id;
`endif

  // A reader is only a candidate while a tag slot is free.
  assign elig0 = m0_write || (m0_read && !fifo_full);
  assign elig1 = m1_write || (m1_read && !fifo_full);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (state == ARB_WR_BURST) begin
      gnt_vld = 1'b1;
      gnt_id  = lock_id;
    end else begin
`ifdef LOCAL_MEM_ARB_RR_EN
      if (elig0 && elig1) begin
        gnt_vld = 1'b1;
        gnt_id  = !last_acc_id;
      end else if (elig0) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (elig1) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
`else
      if (elig0) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (elig1) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
`endif
    end
    if (SoftReset)
      gnt_vld = 1'b0;
  end

  assign sel_read       = gnt_id ? m1_read       : m0_read;
  assign sel_write      = gnt_id ? m1_write      : m0_write;
  assign avs_address    = gnt_id ? m1_address    : m0_address;
  assign avs_writedata  = gnt_id ? m1_writedata  : m0_writedata;
  assign avs_byteenable = gnt_id ? m1_byteenable : m0_byteenable;
  assign avs_burstcount = gnt_id ? m1_burstcount : m0_burstcount;

  assign avs_write      = gnt_vld && sel_write;
  assign avs_read       = gnt_vld && sel_read && !fifo_full;
  assign m0_waitrequest = !(gnt_vld && !gnt_id) || avs_waitrequest;
  assign m1_waitrequest = !(gnt_vld &&  gnt_id) || avs_waitrequest;

  assign accept    = (avs_read || avs_write) && !avs_waitrequest;
  assign fifo_push = accept && avs_read;
  assign push_tag  = '{id: gnt_id, beats: eff_beats(avs_burstcount)};

  always_comb begin
    state_nxt      = state;
    lock_id_nxt    = lock_id;
    beats_left_nxt = beats_left;
    case (state)
      ARB_IDLE: begin
        if (accept && avs_write && (eff_beats(avs_burstcount) > t_local_mem_burst_cnt'(1))) begin
          state_nxt      = ARB_WR_BURST;
          lock_id_nxt    = gnt_id;
          beats_left_nxt = eff_beats(avs_burstcount) - t_local_mem_burst_cnt'(1);
        end
      end
      ARB_WR_BURST: begin
        if (accept && avs_write) begin
          if (beats_left == t_local_mem_burst_cnt'(1)) begin
            state_nxt      = ARB_IDLE;
            beats_left_nxt = '0;
          end else begin
            beats_left_nxt = beats_left - t_local_mem_burst_cnt'(1);
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Command-side control state
  always_ff @(posedge clk or posedge SoftReset) begin
    if (SoftReset) begin
      state      <= ARB_IDLE;
      lock_id    <= 1'b0;
      beats_left <= '0;
    end else begin
      state      <= state_nxt;
      lock_id    <= lock_id_nxt;
      beats_left <= beats_left_nxt;
    end
  end

`ifdef LOCAL_MEM_ARB_RR_EN
  // Reset value makes m0 the preferred requester on the first contest.
  always_ff @(posedge clk or posedge SoftReset) begin
    if (SoftReset)
      last_acc_id <= 1'b1;
    else if (accept && (state == ARB_IDLE))
      last_acc_id <= gnt_id;
  end
`endif

  local_mem_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (SoftReset),
    .push     (fifo_push),
    .push_tag (push_tag),
    .pop      (fifo_pop),
    .head_tag (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Response side: beats belong to the oldest outstanding read.
  assign rdv_hit   = avs_readdatavalid && !fifo_empty;
  assign head_last = ((head_cnt + t_local_mem_burst_cnt'(1)) == head_tag.beats);
  assign fifo_pop  = rdv_hit && head_last;

  always_ff @(posedge clk or posedge SoftReset) begin
    if (SoftReset) begin
      head_cnt  <= '0;
      rsp_error <= 1'b0;
    end else begin
      if (rdv_hit)
        head_cnt <= head_last ? '0 : head_cnt + t_local_mem_burst_cnt'(1);
      if (avs_readdatavalid && fifo_empty)
        rsp_error <= 1'b1;
    end
  end

  assign m0_readdatavalid = rdv_hit && !head_tag.id && !SoftReset;
  assign m1_readdatavalid = rdv_hit &&  head_tag.id && !SoftReset;
  assign m0_readdata      = avs_readdata;
  assign m1_readdata      = avs_readdata;
endmodule

// File: tb/tb_local_mem_arb.sv
// Scoreboard bench for local_mem_arb: expected bank commands and read beats are
// queued as stimulus is issued and retired as the DUT produces them.
module tb_local_mem_arb;
  import local_mem_cfg_pkg::*;

  localparam int TB_TAG_DEPTH = 2;
  localparam int ACC_BOUND    = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 SoftReset;
  t_local_mem_addr      m_address     [2];
  logic                 m_read        [2];
  logic                 m_write       [2];
  t_local_mem_data      m_writedata   [2];
  t_local_mem_byte_mask m_byteenable  [2];
  t_local_mem_burst_cnt m_burstcount  [2];
  logic                 m_waitrequest [2];
  t_local_mem_data      m_readdata    [2];
  logic                 m_readdatavalid [2];

  t_local_mem_addr      avs_address;
  logic                 avs_read, avs_write;
  t_local_mem_data      avs_writedata;
  t_local_mem_byte_mask avs_byteenable;
  t_local_mem_burst_cnt avs_burstcount;
  logic                 avs_waitrequest;
  t_local_mem_data      avs_readdata;
  logic                 avs_readdatavalid;
  logic                 rsp_error;

  local_mem_arb #(
    .TAG_DEPTH (TB_TAG_DEPTH)
  ) dut (
    .clk               (clk),
    .SoftReset         (SoftReset),
    .m0_address        (m_address[0]),
    .m0_read           (m_read[0]),
    .m0_write          (m_write[0]),
    .m0_writedata      (m_writedata[0]),
    .m0_byteenable     (m_byteenable[0]),
    .m0_burstcount     (m_burstcount[0]),
    .m0_waitrequest    (m_waitrequest[0]),
    .m0_readdata       (m_readdata[0]),
    .m0_readdatavalid  (m_readdatavalid[0]),
    .m1_address        (m_address[1]),
    .m1_read           (m_read[1]),
    .m1_write          (m_write[1]),
    .m1_writedata      (m_writedata[1]),
    .m1_byteenable     (m_byteenable[1]),
    .m1_burstcount     (m_burstcount[1]),
    .m1_waitrequest    (m_waitrequest[1]),
    .m1_readdata       (m_readdata[1]),
    .m1_readdatavalid  (m_readdatavalid[1]),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_burstcount    (avs_burstcount),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .rsp_error         (rsp_error)
  );

  typedef struct {
    logic            wr;
    t_local_mem_addr addr;
    t_local_mem_data data;
  } exp_cmd_t;

  typedef struct {
    logic            id;
    t_local_mem_data data;
  } exp_rd_t;

  exp_cmd_t exp_cmd_q [$];
  exp_rd_t  exp_rd_q  [$];
  int n_checks = 0;
  int n_pass   = 0;
  int acc_cnt  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic push_cmd(input logic wr, input t_local_mem_addr addr, input t_local_mem_data data);
    exp_cmd_t e;
    e.wr = wr; e.addr = addr; e.data = data;
    exp_cmd_q.push_back(e);
  endtask

  task automatic push_rd(input logic id, input t_local_mem_data data);
    exp_rd_t r;
    r.id = id; r.data = data;
    exp_rd_q.push_back(r);
  endtask

  // Monitor: retire accepted bank commands and routed read beats.
  always @(negedge clk) begin
    exp_cmd_t e;
    exp_rd_t  r;
    logic     rid;
    if ((avs_read || avs_write) && !avs_waitrequest) begin
      acc_cnt++;
      if (exp_cmd_q.size() == 0) begin
        chk("cmd_unexpected", 64'(avs_address), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_cmd_q.pop_front();
        chk("cmd_kind", 64'(avs_write), 64'(e.wr));
        chk("cmd_addr", 64'(avs_address), 64'(e.addr));
        if (e.wr) chk("cmd_wdata", avs_writedata, e.data);
      end
    end
    if (m_readdatavalid[0] || m_readdatavalid[1]) begin
      chk("rdv_exclusive", 64'(m_readdatavalid[0] && m_readdatavalid[1]), 64'd0);
      rid = m_readdatavalid[1];
      if (exp_rd_q.size() == 0) begin
        chk("rdv_unexpected", 64'(rid), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        r = exp_rd_q.pop_front();
        chk("rdv_owner", 64'(rid), 64'(r.id));
        chk("rdv_data", m_readdata[rid], r.data);
      end
    end
  end

  task automatic wait_accept(input int id);
    int n;
    for (n = 0; n < ACC_BOUND; n++) begin
      @(negedge clk);
      if (!m_waitrequest[id]) break;
    end
    chk("accept_in_time", 64'(n < ACC_BOUND), 64'd1);
  endtask

  // Issue one command (all beats of a write burst) and hold until accepted.
  task automatic drive_cmd(input int id, input logic wr, input t_local_mem_addr addr,
                           input t_local_mem_data data, input int burst);
    int beats;
    beats = (wr && burst > 1) ? burst : 1;
    for (int b = 0; b < beats; b++) begin
      m_address[id]    = addr;
      m_write[id]      = wr;
      m_read[id]       = !wr;
      m_writedata[id]  = data + 64'(b);
      m_burstcount[id] = t_local_mem_burst_cnt'(burst);
      m_byteenable[id] = '1;
      wait_accept(id);
      @(posedge clk); #1;
    end
    m_write[id] = 1'b0;
    m_read[id]  = 1'b0;
  endtask

  task automatic ret_beat(input t_local_mem_data d);
    avs_readdatavalid = 1'b1;
    avs_readdata      = d;
    @(posedge clk); #1;
    avs_readdatavalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int i = 0; i < 2; i++) begin
      m_address[i] = '0; m_read[i] = 1'b0; m_write[i] = 1'b0;
      m_writedata[i] = '0; m_byteenable[i] = '1; m_burstcount[i] = 7'd1;
    end
    avs_waitrequest   = 1'b0;
    avs_readdata      = '0;
    avs_readdatavalid = 1'b0;

    // Reset with live requests and a response beat on the bank.
    SoftReset = 1'b1;
    m_write[0] = 1'b1;
    m_read[1]  = 1'b1;
    avs_readdatavalid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_avs_write", 64'(avs_write), 64'd0);
    chk("rst_avs_read", 64'(avs_read), 64'd0);
    chk("rst_wait0", 64'(m_waitrequest[0]), 64'd1);
    chk("rst_wait1", 64'(m_waitrequest[1]), 64'd1);
    chk("rst_rdv", 64'({m_readdatavalid[1], m_readdatavalid[0]}), 64'd0);
    chk("rst_err", 64'(rsp_error), 64'd0);
    @(posedge clk); #1;
    m_write[0] = 1'b0; m_read[1] = 1'b0; avs_readdatavalid = 1'b0;
    @(posedge clk); #1;
    SoftReset = 1'b0;
    @(posedge clk); #1;

    // Simultaneous single writes: m0 then m1 from a fresh reset.
    push_cmd(1'b1, 32'h0000_0100, 64'hA0);
    push_cmd(1'b1, 32'h0000_0200, 64'hB0);
    fork
      drive_cmd(0, 1'b1, 32'h0000_0100, 64'hA0, 1);
      drive_cmd(1, 1'b1, 32'h0000_0200, 64'hB0, 1);
    join
    // m0 accepted alone, then a contest: priority order depends on the build.
    push_cmd(1'b1, 32'h0000_0110, 64'hA1);
    drive_cmd(0, 1'b1, 32'h0000_0110, 64'hA1, 1);
`ifdef LOCAL_MEM_ARB_RR_EN
    push_cmd(1'b1, 32'h0000_0220, 64'hB2);
    push_cmd(1'b1, 32'h0000_0120, 64'hA2);
`else
    push_cmd(1'b1, 32'h0000_0120, 64'hA2);
    push_cmd(1'b1, 32'h0000_0220, 64'hB2);
`endif
    fork
      drive_cmd(0, 1'b1, 32'h0000_0120, 64'hA2, 1);
      drive_cmd(1, 1'b1, 32'h0000_0220, 64'hB2, 0);
    join

    // m1 four-beat burst stays contiguous while m0 waits and the bank stalls.
    for (int b = 0; b < 4; b++) push_cmd(1'b1, 32'h0000_0300, 64'hC0 + 64'(b));
    push_cmd(1'b1, 32'h0000_0400, 64'hD0);
    base = acc_cnt;
    fork
      drive_cmd(1, 1'b1, 32'h0000_0300, 64'hC0, 4);
      begin
        for (int n = 0; n < ACC_BOUND; n++) begin
          @(posedge clk);
          if (acc_cnt > base) break;
        end
        #1;
        drive_cmd(0, 1'b1, 32'h0000_0400, 64'hD0, 1);
      end
      begin
        for (int n = 0; n < 24; n++) begin
          avs_waitrequest = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        avs_waitrequest = 1'b0;
      end
    join

    // In-order read return: m0 burst 2 then m1 burst 3.
    push_cmd(1'b0, 32'h0000_0500, 64'h0);
    push_cmd(1'b0, 32'h0000_0600, 64'h0);
    drive_cmd(0, 1'b0, 32'h0000_0500, 64'h0, 2);
    drive_cmd(1, 1'b0, 32'h0000_0600, 64'h0, 3);
    for (int k = 0; k < 5; k++) push_rd((k >= 2), 64'h5000 + 64'(k));
    ret_beat(64'h5000);
    ret_beat(64'h5001);
    @(posedge clk); #1;
    ret_beat(64'h5002);
    ret_beat(64'h5003);
    ret_beat(64'h5004);

    // Tag store full: third read held until the first read's last beat.
    push_cmd(1'b0, 32'h0000_0700, 64'h0);
    push_cmd(1'b0, 32'h0000_0710, 64'h0);
    push_cmd(1'b1, 32'h0000_0720, 64'hE0);
    push_cmd(1'b0, 32'h0000_0730, 64'h0);
    drive_cmd(0, 1'b0, 32'h0000_0700, 64'h0, 2);
    drive_cmd(1, 1'b0, 32'h0000_0710, 64'h0, 1);
    drive_cmd(1, 1'b1, 32'h0000_0720, 64'hE0, 1);
    push_rd(1'b0, 64'h7000);
    push_rd(1'b0, 64'h7001);
    fork
      drive_cmd(0, 1'b0, 32'h0000_0730, 64'h0, 1);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("full_wait", 64'(m_waitrequest[0]), 64'd1);
          chk("full_no_read", 64'(avs_read), 64'd0);
        end
        @(posedge clk); #1;
        avs_readdatavalid = 1'b1;
        avs_readdata      = 64'h7000;
        @(negedge clk);
        chk("full_wait_beat1", 64'(m_waitrequest[0]), 64'd1);
        @(posedge clk); #1;
        avs_readdata = 64'h7001;
        @(negedge clk);
        chk("full_wait_pop_cycle", 64'(m_waitrequest[0]), 64'd1);
        chk("full_no_read_pop_cycle", 64'(avs_read), 64'd0);
        @(posedge clk); #1;
        avs_readdatavalid = 1'b0;
        @(negedge clk);
        chk("read_after_pop", 64'(m_waitrequest[0]), 64'd0);
      end
    join
    push_rd(1'b1, 64'h7002);
    push_rd(1'b0, 64'h7003);
    ret_beat(64'h7002);
    ret_beat(64'h7003);

    // Stray response with nothing outstanding.
    @(negedge clk);
    chk("err_before_stray", 64'(rsp_error), 64'd0);
    @(posedge clk); #1;
    ret_beat(64'hDEAD);
    repeat (3) @(negedge clk);
    chk("err_sticky", 64'(rsp_error), 64'd1);
    @(posedge clk); #1;

    // Reset at beat 2 of a four-beat m0 write.
    push_cmd(1'b1, 32'h0000_0800, 64'hF0);
    push_cmd(1'b1, 32'h0000_0800, 64'hF0);
    m_address[0] = 32'h0000_0800; m_writedata[0] = 64'hF0;
    m_burstcount[0] = 7'd4; m_write[0] = 1'b1;
    repeat (2) begin
      wait_accept(0);
      @(posedge clk);
    end
    #1;
    SoftReset  = 1'b1;
    m_write[1] = 1'b1;
    @(negedge clk);
    chk("midburst_rst_avs_write", 64'(avs_write), 64'd0);
    chk("midburst_rst_wait0", 64'(m_waitrequest[0]), 64'd1);
    chk("midburst_rst_wait1", 64'(m_waitrequest[1]), 64'd1);
    chk("midburst_rst_err", 64'(rsp_error), 64'd0);
    @(posedge clk); #1;
    m_write[0] = 1'b0;
    m_write[1] = 1'b0;
    SoftReset  = 1'b0;
    @(posedge clk); #1;
    // Grant must be free again: m1 single write goes straight through.
    push_cmd(1'b1, 32'h0000_0900, 64'h99);
    drive_cmd(1, 1'b1, 32'h0000_0900, 64'h99, 1);
    ret_beat(64'hBEEF);
    @(negedge clk);
    chk("err_after_reset_stray", 64'(rsp_error), 64'd1);

    repeat (2) @(negedge clk);
    chk("cmd_queue_drained", 64'(exp_cmd_q.size()), 64'd0);
    chk("rd_queue_drained", 64'(exp_rd_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/local_mem_arb.md
LOCAL_MEM_ARB -- requirements
Module: local_mem_arb

Interface
REQ-001 Parameter TAG_DEPTH, default 16, SHALL set the number of outstanding read commands tracked (power of 2, range 2..64).
REQ-002 clk  in  1  single clock; all logic SHALL be in this domain.
REQ-003 SoftReset  in  1  reset, asynchronous, active-high.
REQ-004 mN_address (N=0,1)  in  t_local_mem_addr  requester N address.
REQ-005 mN_read / mN_write  in  1 each  requester N read and write command.
REQ-006 mN_writedata  in  t_local_mem_data  requester N write data.
REQ-007 mN_byteenable  in  t_local_mem_byte_mask  requester N byte mask.
REQ-008 mN_burstcount  in  t_local_mem_burst_cnt  requester N burst length.
REQ-009 mN_waitrequest  out  1  stall to requester N.
REQ-010 mN_readdata  out  t_local_mem_data  read data to requester N.
REQ-011 mN_readdatavalid  out  1  read beat valid for requester N.
REQ-012 avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_burstcount  out  (local_mem_cfg_pkg types)  shared memory-bank command port.
REQ-013 avs_waitrequest, avs_readdata, avs_readdatavalid  in  (local_mem_cfg_pkg types)  shared memory-bank slave responses.
REQ-014 rsp_error  out  1  sticky; readdatavalid arrived with no tracked read.

Function
REQ-015 Command path SHALL be a zero-latency mux: avs_* carry the granted requester's signals; granted mN_waitrequest = avs_waitrequest; non-granted mN_waitrequest = 1.
REQ-016 FSM states IDLE and WR_BURST; in IDLE the grant SHALL be recomputed combinationally each cycle among requesters asserting read or write.
REQ-017 A command is accepted when it is on avs_* with avs_waitrequest=0.
REQ-018 Accepted write with burstcount>1: go to WR_BURST, lock the grant to that requester, beats_left = burstcount-1.
REQ-019 In WR_BURST: decrement beats_left per accepted write beat; return to IDLE on the accept with beats_left=1; a lock SHALL never break mid-burst.
REQ-020 Accepted write with burstcount=1 SHALL stay in IDLE.
REQ-021 burstcount=0 SHALL be treated as 1.
REQ-022 Accepted read: push {requester id, burstcount} into the tag FIFO; the FSM SHALL stay in IDLE.
REQ-023 While the tag FIFO is full, no read SHALL be granted: avs_read=0 and the reader's waitrequest=1, even on a same-cycle pop; writes remain grantable.
REQ-024 avs_readdatavalid SHALL route avs_readdata to the head entry's owner in the same cycle (mN_readdatavalid=1), decrement the head beat count, and pop on its last beat.
REQ-025 avs_readdatavalid with the FIFO empty SHALL set rsp_error (cleared only by reset); the beat SHALL be dropped.
REQ-026 mN_readdata SHALL equal avs_readdata unconditionally; only the valid bits are routed.

Reset
REQ-027 While SoftReset=1: FSM=IDLE, FIFO empty, beats_left=0, rsp_error=0, avs_read=avs_write=0, mN_waitrequest=1, mN_readdatavalid=0.
REQ-028 Reset mid-burst or with reads outstanding SHALL discard all state; later stray beats SHALL set rsp_error.

Configuration
REQ-029 Without LOCAL_MEM_ARB_RR_EN: fixed priority, m0 over m1.
REQ-030 With LOCAL_MEM_ARB_RR_EN: round-robin; the requester whose command was last accepted in IDLE gets the lower priority next; the pointer resets to favour m0.

Structure
REQ-031 Package local_mem_arb_pkg SHALL hold the t_arb_state enum, t_arb_tag struct {id, beats} and the default tag depth constant.
REQ-032 Sub-module local_mem_arb_tag_fifo (synchronous FIFO with full/empty flags) SHALL implement the tag store.

Verification
REQ-033 m0 and m1 both write burstcount=1, waitrequest=0 -> fixed priority: m0 accepted first cycle, m1 next; RR build: the requester not accepted last goes first.
REQ-034 m1 write burstcount=4 starts, m0 requests at beat 2, waitrequest toggled -> four m1 beats contiguous on avs_*, then m0 granted.
REQ-035 m0 reads burst 2, then m1 reads burst 3; slave returns 5 beats -> m0 valid 2, then m1 valid 3, in order.
REQ-036 TAG_DEPTH=2, three reads with no responses -> third held waitrequest=1 until the first read's last beat, then accepted.
REQ-037 Stray avs_readdatavalid with no reads outstanding -> rsp_error=1, no mN_readdatavalid.
REQ-038 SoftReset asserted at beat 2 of a 4-beat write -> IDLE, avs_write=0, both waitrequests=1 in reset.
